pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register for the IF/ID/EX/MEM/WB boundaries. It generalises fixed per-stage latch registers to any payload width. It replaces the global Pass/Hold/Bubble stall code with a local valid/ready handshake, a 2-entry skid buffer (full throughput under backpressure) and a synchronous flush that loads bubbles. It sits between two pipeline stages and carries pc, inst, operands and control as one packed payload.

---
 rtl/pipe_skid_stage.sv | 125 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and
// synchronous flush to bubbles. Define STAGE_PERF_EN to add stall/flush counters.
module pipe_skid_stage #(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
`ifdef STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  // Handshake: a payload moves upstream->stage on acc (in_valid_i & in_ready_o)
  // and stage->downstream on fire (out_valid_o & out_ready_i); nothing else moves data.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              acc, fire;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = (state_q != ST_FULL);
  assign out_data_o  = main_q;

  assign acc  = in_valid_i & in_ready_o;
  assign fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Flush wins: any handshake this cycle completes but its payload is dropped.
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            main_d  = in_data_i;
          end
        end
        ST_ONE: begin
          if (acc && fire) begin
            main_d = in_data_i;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_d  = in_data_i;
          end else if (fire) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        ST_FULL: begin
          if (fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_o && !out_ready_i && !flush_i) stall_cnt_d = stall_cnt_q + 32'd1;
    // Flushing an already-empty stage kills nothing, so it is not counted.
    if (flush_i && (state_q != ST_EMPTY)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, asynchronous reset check and
// randomized traffic against a queue-based reference model.
module tb_pipe_skid_stage;
  localparam int              W      = 16;
  localparam logic [W-1:0]    BUBBLE = 16'h0013;

  logic         clk;
  logic         rst;
  logic         flush_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] in_data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_data_o;
`ifdef STAGE_PERF_EN
  logic [31:0]  stall_cnt_o;
  logic [31:0]  flush_cnt_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  pipe_skid_stage #(.DATA_W(W), .BUBBLE_VAL(BUBBLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
`ifdef STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         f;
    logic         e_ov;
    logic         e_ir;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t vecs[15];

  // scoreboard: expected contents of the stage, head first
  logic [W-1:0] exp_q[$];
  int unsigned  exp_stall;
  int unsigned  exp_flush;

  initial begin
    // streaming
    vecs[0]  = '{1'b1, 16'h0011, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011};
    vecs[1]  = '{1'b1, 16'h0022, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0022};
    vecs[2]  = '{1'b1, 16'h0033, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0033};
    // drain to empty
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, BUBBLE};
    // backpressure, fill to FULL, extra offer ignored, then release
    vecs[4]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00A1};
    vecs[5]  = '{1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00A1};
    vecs[6]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00A1};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00A2};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, BUBBLE};
    // flush while FULL with simultaneous offer of 0xBB
    vecs[9]  = '{1'b1, 16'h00C1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00C1};
    vecs[10] = '{1'b1, 16'h00C2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00C1};
    vecs[11] = '{1'b1, 16'h00BB, 1'b0, 1'b1, 1'b0, 1'b1, BUBBLE};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, BUBBLE};
    // flush with accept from EMPTY drops the payload
    vecs[13] = '{1'b1, 16'h00D1, 1'b1, 1'b1, 1'b0, 1'b1, BUBBLE};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, BUBBLE};

    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("reset_in_ready",  {31'd0, in_ready_o},  32'd1);
    check("reset_out_data",  {16'd0, out_data_o},  {16'd0, BUBBLE});

    // directed table
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid_o}, {31'd0, vecs[i].e_ov});
      check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready_o},  {31'd0, vecs[i].e_ir});
      check($sformatf("vec%0d_out_data", i),  {16'd0, out_data_o},  {16'd0, vecs[i].e_od});
    end

    // asynchronous reset from FULL, checked before any clock edge
    @(negedge clk);
    drive(1'b1, 16'h00E1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h00E2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_full", {31'd0, in_ready_o}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("async_rst_in_ready",  {31'd0, in_ready_o},  32'd1);
    check("async_rst_out_data",  {16'd0, out_data_o},  {16'd0, BUBBLE});
`ifdef STAGE_PERF_EN
    check("async_rst_stall_cnt", stall_cnt_o, 32'd0);
    check("async_rst_flush_cnt", flush_cnt_o, 32'd0);
`endif
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;

    // randomized traffic against the queue model
    exp_q.delete();
    exp_stall = 0;
    exp_flush = 0;
    for (int c = 0; c < 2000; c++) begin
      logic         v, r, f, acc, fire;
      logic [W-1:0] d;
      @(negedge clk);
      check("rnd_out_valid", {31'd0, out_valid_o}, {31'd0, exp_q.size() > 0});
      check("rnd_in_ready",  {31'd0, in_ready_o},  {31'd0, exp_q.size() < 2});
      check("rnd_out_data",  {16'd0, out_data_o},
            {16'd0, (exp_q.size() > 0) ? exp_q[0] : BUBBLE});
`ifdef STAGE_PERF_EN
      check("rnd_stall_cnt", stall_cnt_o, exp_stall);
      check("rnd_flush_cnt", flush_cnt_o, exp_flush);
`endif
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 19) == 0);
      d = W'($urandom);
      drive(v, d, r, f);
      acc  = v && (exp_q.size() < 2);
      fire = r && (exp_q.size() > 0);
      if (exp_q.size() > 0 && !r && !f) exp_stall++;
      if (f && exp_q.size() > 0) exp_flush++;
      @(posedge clk);
      if (f) exp_q.delete();
      else begin
        if (fire) void'(exp_q.pop_front());
        if (acc)  exp_q.push_back(d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
